// File: rtl/cnn_pkg.sv
// Shared CNN datapath constants and activation helpers.
// Used by the conv post-processing stage and the FC stage.
package cnn_pkg;

  localparam int DATA_W  = 8;
  localparam int ACC_W   = 24;
  localparam int ACT_MAX = (1 << (DATA_W - 1)) - 1;

  function automatic logic [DATA_W-1:0] max8(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    // Activations are always non-negative, so an unsigned compare is exact.
    return (a > b) ? a : b;
  endfunction

  function automatic logic [DATA_W-1:0] sat_relu(
    input logic signed [ACC_W:0] s
  );
    if (s[ACC_W])
      return '0;
    else if (s > $signed((ACC_W + 1)'(ACT_MAX)))
      return DATA_W'(ACT_MAX);
    else
      return s[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/relu_requant.sv
// Stage 1: bias add, ReLU, requant shift and 8-bit clamp, registered.
// Ports: valid_in/sum_in/bias/col_in/row_in in; q_out/v_out/col_out/row_out out.
module relu_requant #(
  parameter int DATA_W = cnn_pkg::DATA_W,
  parameter int ACC_W  = cnn_pkg::ACC_W,
  parameter int SHIFT  = 8,
  parameter int CW     = 5,
  parameter int RW     = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic [ACC_W-1:0]  sum_in,
  input  logic [ACC_W-1:0]  bias,
  input  logic [CW-1:0]     col_in,
  input  logic [RW-1:0]     row_in,
  output logic [DATA_W-1:0] q_out,
  output logic              v_out,
  output logic [CW-1:0]     col_out,
  output logic [RW-1:0]     row_out
);
  import cnn_pkg::*;

  logic signed [ACC_W:0] t_w;
  logic signed [ACC_W:0] s_w;

  logic [DATA_W-1:0] q_d, q_q;
  logic              v_d, v_q;
  logic [CW-1:0]     col_d, col_q;
  logic [RW-1:0]     row_d, row_q;

  always_comb begin
    t_w   = $signed({sum_in[ACC_W-1], sum_in})
          + $signed({bias[ACC_W-1], bias});
    s_w   = t_w >>> SHIFT;
    v_d   = valid_in;
    q_d   = q_q;
    col_d = col_q;
    row_d = row_q;
    if (valid_in) begin
      q_d   = sat_relu(s_w);
      col_d = col_in;
      row_d = row_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q   <= '0;
      v_q   <= 1'b0;
      col_q <= '0;
      row_q <= '0;
    end else begin
      q_q   <= q_d;
      v_q   <= v_d;
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign q_out   = q_q;
  assign v_out   = v_q;
  assign col_out = col_q;
  assign row_out = row_q;

endmodule

// File: rtl/relu_requant_maxpool2x2.sv
// ReLU + requant + 2x2/stride-2 max pool over a raster conv output stream.
// Ports: valid_in/sof/sum_in/bias in; pool_out/valid_out/frame_done out.
module relu_requant_maxpool2x2 #(
  parameter int DATA_W = cnn_pkg::DATA_W,
  parameter int ACC_W  = cnn_pkg::ACC_W,
  parameter int IMG_W  = 24,
  parameter int IMG_H  = 24,
  parameter int SHIFT  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic              sof,
  input  logic [ACC_W-1:0]  sum_in,
  input  logic [ACC_W-1:0]  bias,
  output logic [DATA_W-1:0] pool_out,
  output logic              valid_out,
  output logic              frame_done
);
  import cnn_pkg::*;

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int PW = IMG_W / 2;
  localparam int KW = (PW > 1) ? $clog2(PW) : 1;

  logic [CW-1:0] col_d, col_q, tag_c;
  logic [RW-1:0] row_d, row_q, tag_r;

  logic [DATA_W-1:0] q1;
  logic              v1;
  logic [CW-1:0]     c1;
  logic [RW-1:0]     r1;

  logic [DATA_W-1:0] hold_d, hold_q;
  logic [DATA_W-1:0] pool_d, pool_q;
  logic              valid_d, valid_q;
  logic              done_d, done_q;

  logic [DATA_W-1:0] rowbuf [PW];
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic [KW-1:0]     k;
  logic              drop;
  logic              last;

  // sof overrides the counters so a truncated frame resyncs here.
  always_comb begin
    tag_c = col_q;
    tag_r = row_q;
    col_d = col_q;
    row_d = row_q;
    if (valid_in) begin
      if (sof) begin
        tag_c = '0;
        tag_r = '0;
      end
      if (tag_c == CW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (tag_r == RW'(IMG_H - 1)) ? '0 : tag_r + 1'b1;
      end else begin
        col_d = tag_c + 1'b1;
        row_d = tag_r;
      end
    end
  end

  relu_requant #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .SHIFT  (SHIFT),
    .CW     (CW),
    .RW     (RW)
  ) u_s1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_in (valid_in),
    .sum_in   (sum_in),
    .bias     (bias),
    .col_in   (tag_c),
    .row_in   (tag_r),
    .q_out    (q1),
    .v_out    (v1),
    .col_out  (c1),
    .row_out  (r1)
  );

  // Odd trailing column/row never completes a window.
  always_comb begin
    k    = KW'(c1 >> 1);
    drop = ((IMG_W % 2 == 1) && (c1 == CW'(IMG_W - 1)))
        || ((IMG_H % 2 == 1) && (r1 == RW'(IMG_H - 1)));
    last = (k == KW'(PW - 1))
        && (RW'(r1 >> 1) == RW'(IMG_H / 2 - 1));
    hold_d  = hold_q;
    pool_d  = pool_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    wr_en   = 1'b0;
    wr_data = max8(hold_q, q1);
    if (v1 && !drop) begin
      unique case (1'b1)
        (!r1[0] && !c1[0]): hold_d = q1;
        (!r1[0] &&  c1[0]): wr_en  = 1'b1;
        ( r1[0] && !c1[0]): hold_d = max8(q1, rowbuf[k]);
        default: begin
          pool_d  = max8(hold_q, q1);
          valid_d = 1'b1;
          done_d  = last;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      rowbuf[k] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q   <= '0;
      row_q   <= '0;
      hold_q  <= '0;
      pool_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      hold_q  <= hold_d;
      pool_q  <= pool_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign pool_out   = pool_q;
  assign valid_out  = valid_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_relu_requant_maxpool2x2.sv
// Scoreboard bench: three DUT configs (2x2/SHIFT8, 4x4/SHIFT0, 5x5/SHIFT0).
// Stimulus pushes expected outputs; a negedge monitor pops and compares.
module tb_relu_requant_maxpool2x2;

  logic       clk;
  logic       rst_n;
  logic       v_in   [3];
  logic       sof_in [3];
  logic [23:0] sum   [3];
  logic [23:0] bias  [3];
  logic [7:0] po     [3];
  logic       vo     [3];
  logic       fd     [3];
  logic       pv     [3];

  typedef struct {
    int         dut;
    int         cyc;
    logic [7:0] val;
    logic       done;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   cyc;
  int   n_vec;
  int   n_err;

  relu_requant_maxpool2x2 #(
    .IMG_W(2), .IMG_H(2), .SHIFT(8)
  ) u_d0 (
    .clk(clk), .rst_n(rst_n), .valid_in(v_in[0]), .sof(sof_in[0]),
    .sum_in(sum[0]), .bias(bias[0]), .pool_out(po[0]),
    .valid_out(vo[0]), .frame_done(fd[0])
  );

  relu_requant_maxpool2x2 #(
    .IMG_W(4), .IMG_H(4), .SHIFT(0)
  ) u_d1 (
    .clk(clk), .rst_n(rst_n), .valid_in(v_in[1]), .sof(sof_in[1]),
    .sum_in(sum[1]), .bias(bias[1]), .pool_out(po[1]),
    .valid_out(vo[1]), .frame_done(fd[1])
  );

  relu_requant_maxpool2x2 #(
    .IMG_W(5), .IMG_H(5), .SHIFT(0)
  ) u_d2 (
    .clk(clk), .rst_n(rst_n), .valid_in(v_in[2]), .sof(sof_in[2]),
    .sum_in(sum[2]), .bias(bias[2]), .pool_out(po[2]),
    .valid_out(vo[2]), .frame_done(fd[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (vo[d]) begin
        n_vec++;
        if (sbq.size() == 0 || sbq[0].dut != d) begin
          n_err++;
          $display("FAIL unexpected_out dut%0d pool_out=%0d cyc=%0d",
                   d, po[d], cyc);
        end else begin
          mon_e = sbq.pop_front();
          if (po[d] !== mon_e.val || fd[d] !== mon_e.done
              || cyc != mon_e.cyc) begin
            n_err++;
            $display("FAIL pool dut%0d got val=%0d done=%0b cyc=%0d want val=%0d done=%0b cyc=%0d",
                     d, po[d], fd[d], cyc, mon_e.val, mon_e.done, mon_e.cyc);
          end
        end
        if (pv[d]) begin
          n_vec++;
          n_err++;
          $display("FAIL back_to_back dut%0d valid_out=1 want 0", d);
        end
      end else if (fd[d] !== 1'b0) begin
        n_vec++;
        n_err++;
        $display("FAIL stray_done dut%0d frame_done=%0b want 0", d, fd[d]);
      end
      pv[d] = vo[d];
    end
  end

  task automatic chk_zero(input int d, input string name);
    n_vec++;
    if (po[d] !== 8'd0 || vo[d] !== 1'b0 || fd[d] !== 1'b0) begin
      n_err++;
      $display("FAIL %s dut%0d got po=%0d vo=%0b fd=%0b want 0/0/0",
               name, d, po[d], vo[d], fd[d]);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input int v, input logic s,
                      input bit e, input int ev, input logic ed);
    sum[d]    = 24'(v);
    sof_in[d] = s;
    v_in[d]   = 1'b1;
    if (e) sbq.push_back('{d, cyc + 2, 8'(ev), ed});
    @(posedge clk);
    #1;
    v_in[d]   = 1'b0;
    sof_in[d] = 1'b0;
  endtask

  // 2x2 window of identical values on the 2x2 map.
  task automatic window0(input int v, input int ev, input logic s);
    send(0, v, s, 0, 0, 0);
    send(0, v, 0, 0, 0, 0);
    send(0, v, 0, 0, 0, 0);
    send(0, v, 0, 1, ev, 1'b1);
  endtask

  task automatic frame4(input bit gap, input logic s, input int n);
    int br[4];
    br = '{5, 7, 13, 15};
    for (int p = 0; p < n; p++) begin
      bit e;
      int ev;
      logic ed;
      e  = 0;
      ev = 0;
      ed = 0;
      for (int i = 0; i < 4; i++)
        if (p == br[i]) begin
          e  = 1;
          ev = br[i];
          ed = (i == 3);
        end
      send(1, p, (p == 0) ? s : 1'b0, e, ev, ed);
      if (gap) idle(1);
    end
  endtask

  task automatic frame5();
    int br[4];
    br = '{6, 8, 16, 18};
    for (int p = 0; p < 25; p++) begin
      bit e;
      int ev;
      logic ed;
      e  = 0;
      ev = 0;
      ed = 0;
      for (int i = 0; i < 4; i++)
        if (p == br[i]) begin
          e  = 1;
          ev = br[i];
          ed = (i == 3);
        end
      send(2, p, p == 0, e, ev, ed);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      v_in[d]   = 1'b0;
      sof_in[d] = 1'b0;
      sum[d]    = '0;
      bias[d]   = '0;
      pv[d]     = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) chk_zero(d, "reset_state");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    window0(-5000, 0, 1'b1);
    window0(1280, 5, 1'b0);
    window0(40000, 127, 1'b0);
    window0(255, 0, 1'b0);
    bias[0] = 24'(-512);
    window0(1792, 5, 1'b0);
    idle(4);

    frame4(0, 1'b1, 16);
    idle(4);
    frame4(1, 1'b0, 16);
    idle(4);
    frame4(0, 1'b1, 6);
    idle(4);
    frame4(0, 1'b1, 16);
    idle(4);
    frame4(0, 1'b0, 6);
    idle(4);
    rst_n = 1'b0;
    @(negedge clk);
    chk_zero(1, "mid_reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    frame4(0, 1'b0, 16);
    idle(4);

    frame5();
    idle(6);

    if (sbq.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain pending=%0d want 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
